switch_in_arbiter: RTL and testbench



---
 rtl/switch_in_arbiter.sv | 120 ++++++++++++
 tb/tb_switch_in_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/switch_in_arbiter.sv
// Round-robin ingress arbiter for the switch. NUM_REQ requesters share the
// single vld/addr/data ingress. Each grant lasts for up to BURST_LEN beats.
// Accepted beats pass through one registered output stage that honours
// downstream backpressure (out_rdy).
module switch_in_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic                          out_vld,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_rdy,
  output logic                          gnt_vld,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  beat_cnt;

  logic           out_stage_free;
  logic           accept;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] next_ptr;

  assign gnt_vld        = (state == GRANT);
  assign out_stage_free = !out_vld || out_rdy;
  assign accept         = gnt_vld && req_vld[gnt_id] && out_stage_free;
  assign next_ptr       = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  // Only the current grantee sees ready, and only when the output stage can take a beat.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req_rdy = '0;
    if (gnt_vld && out_stage_free) req_rdy[gnt_id] = 1'b1;
  end

  // Round-robin search: first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    // Walk from farthest to nearest so the nearest hit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_vld[IDW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // Grant FSM: IDLE arbitrates (one bubble cycle), GRANT streams a burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      beat_cnt <= '0;
      gnt_id   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            gnt_id   <= win_id;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (!req_vld[gnt_id]) begin
            // Early release, whether or not the output stage is stalled.
            state <= IDLE;
            ptr   <= next_ptr;
          end else if (accept) begin
            if (beat_cnt == CW'(BURST_LEN - 1)) begin
              state    <= IDLE;
              ptr      <= next_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load on an accepted beat, drain when downstream is ready, else hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else if (accept) begin
      out_vld  <= 1'b1;
      out_addr <= req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
      out_data <= req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_in_arbiter.sv
// Directed bench for switch_in_arbiter (4 requesters, burst 4).
// Requester i presents addr (i+1)*16+n and data {4'hD, i, addr} for its n-th beat.
module tb_switch_in_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_vld;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  req_rdy;
  logic        out_vld;
  logic [7:0]  out_addr;
  logic [15:0] out_data;
  logic        out_rdy;
  logic        gnt_vld;
  logic [1:0]  gnt_id;

  int          errors = 0;
  int          checks = 0;
  int          cnt [4];
  logic [3:0]  acc;

  switch_in_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(16), .BURST_LEN(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_vld(req_vld), .req_addr(req_addr), .req_data(req_data), .req_rdy(req_rdy),
    .out_vld(out_vld), .out_addr(out_addr), .out_data(out_data), .out_rdy(out_rdy),
    .gnt_vld(gnt_vld), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_addr(input int id, input int n);
    return 8'((id + 1) * 16 + n);
  endfunction

  function automatic logic [15:0] exp_data(input int id, input int n);
    return {4'hD, 4'(id), exp_addr(id, n)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*8 +: 8]   = exp_addr(i, cnt[i]);
      req_data[i*16 +: 16] = exp_data(i, cnt[i]);
    end
  endtask

  // Advance one cycle: retire beats accepted at this edge, apply new inputs,
  // and return at the following falling edge for checking.
  task automatic step(input logic [3:0] v, input logic o);
    acc = req_vld & req_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) cnt[i]++;
    req_vld = v;
    out_rdy = o;
    drive_bus();
    @(negedge clk);
  endtask

  task automatic expect_st(input string tag, input logic gv, input int gid,
                           input logic [3:0] rr, input logic ov, input int oid, input int on);
    check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(gv));
    if (gv) check({tag, ".gnt_id"}, 32'(gnt_id), 32'(gid));
    check({tag, ".req_rdy"}, 32'(req_rdy), 32'(rr));
    check({tag, ".out_vld"}, 32'(out_vld), 32'(ov));
    if (ov) begin
      check({tag, ".out_addr"}, 32'(out_addr), 32'(exp_addr(oid, on)));
      check({tag, ".out_data"}, 32'(out_data), 32'(exp_data(oid, on)));
    end
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    req_vld = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_bus();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b0;
    req_vld = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_bus();
    #2;
    check("rst.out_vld",  32'(out_vld),  32'd0);
    check("rst.out_addr", 32'(out_addr), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.gnt_vld",  32'(gnt_vld),  32'd0);
    check("rst.gnt_id",   32'(gnt_id),   32'd0);
    check("rst.req_rdy",  32'(req_rdy),  32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single requester: bubble, 4 beats, bubble, re-grant, then early release.
    step(4'b0001, 1'b1); expect_st("t1_idle",  0, 0, 4'b0000, 0, 0, 0);
    step(4'b0001, 1'b1); expect_st("t1_gnt",   1, 0, 4'b0001, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      step(4'b0001, 1'b1);
      expect_st("t1_beat", b < 3, 0, (b < 3) ? 4'b0001 : 4'b0000, 1, 0, b);
    end
    step(4'b0001, 1'b1); expect_st("t1_regnt", 1, 0, 4'b0001, 0, 0, 0);
    step(4'b0000, 1'b1); expect_st("t1_last",  1, 0, 4'b0001, 1, 0, 4);
    step(4'b0000, 1'b1); expect_st("t1_rel",   0, 0, 4'b0000, 0, 0, 0);

    // All four requesters: grant order 0,1,2,3,0 with 4 beats each.
    do_reset();
    step(4'b1111, 1'b1); expect_st("t2_idle", 0, 0, 4'b0000, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 1'b1);
      expect_st("t2_gnt", 1, g % 4, 4'(1 << (g % 4)), 0, 0, 0);
      for (int b = 0; b < 4; b++) begin
        step(4'b1111, 1'b1);
        expect_st("t2_beat", b < 3, g % 4, (b < 3) ? 4'(1 << (g % 4)) : 4'b0000,
                  1, g % 4, (g / 4) * 4 + b);
      end
    end

    // Backpressure: requester 2, out_rdy low for 3 cycles after its second beat.
    do_reset();
    step(4'b0100, 1'b1); expect_st("t3_idle",  0, 0, 4'b0000, 0, 0, 0);
    step(4'b0100, 1'b1); expect_st("t3_gnt",   1, 2, 4'b0100, 0, 0, 0);
    step(4'b0100, 1'b1); expect_st("t3_b0",    1, 2, 4'b0100, 1, 2, 0);
    for (int s = 0; s < 3; s++) begin
      step(4'b0100, 1'b0); expect_st("t3_stall", 1, 2, 4'b0000, 1, 2, 1);
    end
    step(4'b0100, 1'b1); expect_st("t3_resume", 1, 2, 4'b0100, 1, 2, 1);
    step(4'b0100, 1'b1); expect_st("t3_b2",     1, 2, 4'b0100, 1, 2, 2);
    step(4'b0100, 1'b1); expect_st("t3_b3",     0, 0, 4'b0000, 1, 2, 3);
    step(4'b0000, 1'b1); expect_st("t3_nomore", 1, 2, 4'b0100, 0, 0, 0);

    // Early release: requester 1 drops after 2 beats, requester 3 waiting.
    do_reset();
    step(4'b1010, 1'b1); expect_st("t4_idle", 0, 0, 4'b0000, 0, 0, 0);
    step(4'b1010, 1'b1); expect_st("t4_gnt1", 1, 1, 4'b0010, 0, 0, 0);
    step(4'b1010, 1'b1); expect_st("t4_b0",   1, 1, 4'b0010, 1, 1, 0);
    step(4'b1000, 1'b1); expect_st("t4_b1",   1, 1, 4'b0010, 1, 1, 1);
    step(4'b1000, 1'b1); expect_st("t4_rel",  0, 0, 4'b0000, 0, 0, 0);
    step(4'b1000, 1'b1); expect_st("t4_gnt3", 1, 3, 4'b1000, 0, 0, 0);
    step(4'b1000, 1'b1); expect_st("t4_3b0",  1, 3, 4'b1000, 1, 3, 0);

    // Wrap: bring ptr to 3 via a short grant to 2, then req_vld=1001.
    do_reset();
    step(4'b0100, 1'b1); expect_st("t5_idle", 0, 0, 4'b0000, 0, 0, 0);
    step(4'b0100, 1'b1); expect_st("t5_gnt2", 1, 2, 4'b0100, 0, 0, 0);
    step(4'b1001, 1'b1); expect_st("t5_2b0",  1, 2, 4'b0100, 1, 2, 0);
    step(4'b1001, 1'b1); expect_st("t5_rel",  0, 0, 4'b0000, 0, 0, 0);
    step(4'b1001, 1'b1); expect_st("t5_gnt3", 1, 3, 4'b1000, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      step(4'b1001, 1'b1);
      expect_st("t5_beat", b < 3, 3, (b < 3) ? 4'b1000 : 4'b0000, 1, 3, b);
    end
    step(4'b1001, 1'b1); expect_st("t5_gnt0", 1, 0, 4'b0001, 0, 0, 0);

    // Async reset while requester 1's second beat is on the output.
    do_reset();
    step(4'b0010, 1'b1); expect_st("t6_idle", 0, 0, 4'b0000, 0, 0, 0);
    step(4'b0010, 1'b1); expect_st("t6_gnt",  1, 1, 4'b0010, 0, 0, 0);
    step(4'b0010, 1'b1); expect_st("t6_b0",   1, 1, 4'b0010, 1, 1, 0);
    step(4'b0010, 1'b1); expect_st("t6_b1",   1, 1, 4'b0010, 1, 1, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst.out_vld",  32'(out_vld),  32'd0);
    check("t6_rst.out_addr", 32'(out_addr), 32'd0);
    check("t6_rst.gnt_vld",  32'(gnt_vld),  32'd0);
    check("t6_rst.gnt_id",   32'(gnt_id),   32'd0);
    check("t6_rst.req_rdy",  32'(req_rdy),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(4'b0010, 1'b1); expect_st("t6_after", 1, 1, 4'b0010, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
